// File: rtl/pll_reset_sequencer_pkg.sv
// rtl/pll_reset_sequencer_pkg.sv - state encoding and counter sizing for the PLL reset sequencer
package pll_reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    // Width needed for one down-counter that serves both the stable and hold phases.
    function automatic int cnt_width(input int stable_cycles, input int hold_cycles);
        int m;
        m = (stable_cycles > hold_cycles) ? stable_cycles : hold_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - lock/reset control bundle between the PLL domain and the sequencer
interface pll_reset_sequencer_if #(
    parameter int LOSS_CNT_W = 8
);
    logic                  locked;
    logic                  soft_reset_req;
    logic                  reset_out;
    logic                  ready;
    logic [LOSS_CNT_W-1:0] lock_loss_count;
    logic [1:0]            state;

    modport master (
        output locked,
        output soft_reset_req,
        input  reset_out,
        input  ready,
        input  lock_loss_count,
        input  state
    );

    modport slave (
        input  locked,
        input  soft_reset_req,
        output reset_out,
        output ready,
        output lock_loss_count,
        output state
    );
endinterface

// File: rtl/pll_reset_sequencer_sync_ff.sv
// rtl/pll_reset_sequencer_sync_ff.sv - multi-stage single-bit synchronizer with asynchronous clear
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - qualifies PLL lock and releases the PLL-domain reset synchronously
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int RESET_HOLD_CYCLES  = 8,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                  clock_in,
    input  logic                  reset,
    pll_reset_sequencer_if.slave  bus
);
    localparam int CW = cnt_width(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
    // The WAIT_LOCK cycle that first sees locked_s high is the first stable cycle,
    // so STABLE itself only has LOCK_STABLE_CYCLES-1 cycles left to run.
    localparam logic [CW-1:0] STABLE_LOAD = CW'((LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0);
    localparam logic [CW-1:0] HOLD_LOAD   = CW'(RESET_HOLD_CYCLES - 1);

    logic                  locked_s;
    seq_state_t            st;
    logic [CW-1:0]         cnt;
    logic                  reset_q;
    logic                  ready_q;
    logic [LOSS_CNT_W-1:0] loss_q;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clock_in),
        .clr (reset),
        .d   (bus.locked),
        .q   (locked_s)
    );

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            st      <= WAIT_LOCK;
            cnt     <= '0;
            reset_q <= 1'b1;
            ready_q <= 1'b0;
            loss_q  <= '0;
        end else begin
            case (st)
                WAIT_LOCK: begin
                    reset_q <= 1'b1;
                    ready_q <= 1'b0;
                    if (locked_s) begin
                        if (LOCK_STABLE_CYCLES == 1) begin
                            st  <= HOLD;
                            cnt <= HOLD_LOAD;
                        end else begin
                            st  <= STABLE;
                            cnt <= STABLE_LOAD;
                        end
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        st <= WAIT_LOCK;
                    end else if (cnt == '0) begin
                        st  <= HOLD;
                        cnt <= HOLD_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (!locked_s) begin
                        st <= WAIT_LOCK;
                    end else if (cnt == '0) begin
                        st      <= RUN;
                        reset_q <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RUN: begin
                    // Lock loss takes priority over a coincident soft reset so it is always counted.
                    if (!locked_s) begin
                        st      <= WAIT_LOCK;
                        reset_q <= 1'b1;
                        ready_q <= 1'b0;
                        if (loss_q != '1) begin
                            loss_q <= loss_q + 1'b1;
                        end
                    end else if (bus.soft_reset_req) begin
                        st      <= WAIT_LOCK;
                        reset_q <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    st      <= WAIT_LOCK;
                    reset_q <= 1'b1;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.reset_out       = reset_q;
    assign bus.ready           = ready_q;
    assign bus.lock_loss_count = loss_q;
    assign bus.state           = st;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for pll_reset_sequencer
module tb_pll_reset_sequencer;
    localparam int S = 2;
    localparam int L = 16;
    localparam int H = 8;
    localparam int W = 8;
    localparam int N = S + L + H;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pll_reset_sequencer_if #(.LOSS_CNT_W(W)) bus ();

    pll_reset_sequencer #(
        .SYNC_STAGES        (S),
        .LOCK_STABLE_CYCLES (L),
        .RESET_HOLD_CYCLES  (H),
        .LOSS_CNT_W         (W)
    ) dut (
        .clock_in (clk),
        .reset    (rst),
        .bus      (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int           cyc;
        logic         val;
        logic [W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    logic prev_ro = 1'b1;
    bit   mon_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic v, input int cnt);
        exp_t e;
        e.cyc = c;
        e.val = v;
        e.cnt = W'(cnt);
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    // Monitor: every reset_out transition must match the next queued expectation.
    always @(negedge clk) begin
        if (mon_en && (bus.reset_out !== prev_ro)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_edge: reset_out went to %0b at cycle %0d, none expected",
                         bus.reset_out, cyc);
            end else begin
                mon_e = q.pop_front();
                check("edge_cycle", cyc, mon_e.cyc);
                check("edge_value", bus.reset_out, mon_e.val);
                check("edge_count", bus.lock_loss_count, mon_e.cnt);
                check("edge_ready", bus.ready, !mon_e.val);
                check("edge_state", bus.state, mon_e.val ? 0 : 3);
            end
        end
        prev_ro = bus.reset_out;
    end

    int c;
    int d;

    initial begin
        rst                = 1'b1;
        bus.locked         = 1'b0;
        bus.soft_reset_req = 1'b0;

        // Reset and idle without lock
        step(5);
        check("rst_reset_out", bus.reset_out, 1);
        check("rst_ready", bus.ready, 0);
        check("rst_state", bus.state, 0);
        check("rst_count", bus.lock_loss_count, 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(25);
            check("idle_reset_out", bus.reset_out, 1);
            check("idle_ready", bus.ready, 0);
            check("idle_state", bus.state, 0);
        end

        // One-cycle lock glitch restarts qualification
        c = cyc;
        bus.locked = 1'b1;
        push(c + 11 + N, 1'b0, 0);
        step(10);
        bus.locked = 1'b0;
        step(1);
        bus.locked = 1'b1;
        step(N + 2);
        check("glitch_count", bus.lock_loss_count, 0);
        check("glitch_state", bus.state, 3);

        // Lock loss in RUN, then full re-qualification
        c = cyc;
        bus.locked = 1'b0;
        push(c + 1 + S, 1'b1, 1);
        step(4);
        c = cyc;
        bus.locked = 1'b1;
        push(c + N, 1'b0, 1);
        step(N + 2);

        // Soft reset coincident with lock loss counts once
        c = cyc;
        bus.locked = 1'b0;
        push(c + 1 + S, 1'b1, 2);
        step(S);
        bus.soft_reset_req = 1'b1;
        step(1);
        bus.soft_reset_req = 1'b0;
        step(2);
        check("coincident_count", bus.lock_loss_count, 2);
        c = cyc;
        bus.locked = 1'b1;
        push(c + N, 1'b0, 2);
        step(N + 2);

        // Lone soft reset: next-edge reassert, no count, full re-release
        c = cyc;
        bus.soft_reset_req = 1'b1;
        push(c + 1, 1'b1, 2);
        push(c + 1 + L + H, 1'b0, 2);
        step(1);
        bus.soft_reset_req = 1'b0;
        step(L + H + 2);
        check("soft_count", bus.lock_loss_count, 2);

        // Saturate the loss counter
        for (int n = 3; n <= 300; n++) begin
            c = cyc;
            bus.locked = 1'b0;
            push(c + 1 + S, 1'b1, sat(n));
            step(4);
            c = cyc;
            bus.locked = 1'b1;
            push(c + N, 1'b0, sat(n));
            step(N + 2);
        end
        check("sat_count", bus.lock_loss_count, 255);

        // Reset asserted mid-HOLD
        c = cyc;
        bus.locked = 1'b0;
        push(c + 1 + S, 1'b1, 255);
        step(4);
        c = cyc;
        bus.locked = 1'b1;
        step(22);
        check("hold_state", bus.state, 2);
        rst = 1'b1;
        #1;
        check("async_state", bus.state, 0);
        check("async_count", bus.lock_loss_count, 0);
        step(2);
        check("midhold_reset_out", bus.reset_out, 1);
        check("midhold_ready", bus.ready, 0);
        check("midhold_state", bus.state, 0);
        check("midhold_count", bus.lock_loss_count, 0);
        d = cyc;
        rst = 1'b0;
        push(d + N, 1'b0, 0);
        step(N + 2);

        check("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
